// File: rtl/time_stamp_sched.sv
// ---------------------------------------------------------------------------
// time_stamp_sched
//
// Captures interrupt time stamps for VecSize pend lines through one shared
// stamp write port. A rising edge on an enabled pend line queues a single
// capture request for that vector. A round-robin arbiter grants one request
// per cycle. The stamp written for the grant is back-corrected by the
// request's age, so it always equals the timer value of the edge cycle.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   mono_timer   free-running timer, +1 per clk, wraps
//   pend         per-vector pending lines
//   cap_enable   per-vector capture mask (0 = ignore edges)
//   overrun_clr  per-vector clear of the sticky overrun flag
//   ts_we        stamp write strobe, one cycle per stamp
//   ts_idx       vector index being written (held while ts_we=0)
//   ts_data      stamp value (held while ts_we=0)
//   overrun      sticky: an edge was lost while a request was outstanding
//   busy         any request outstanding
// ---------------------------------------------------------------------------
module time_stamp_sched #(
   parameter int VecSize            = 8,
   parameter int TimerWidth         = 32,
   parameter int TimeStampWidth     = 16,
   parameter int TimeStampPreScaler = 4,
   localparam int IdxW              = (VecSize > 1) ? $clog2(VecSize) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [TimerWidth-1:0]     mono_timer,
   input  logic [VecSize-1:0]        pend,
   input  logic [VecSize-1:0]        cap_enable,
   input  logic [VecSize-1:0]        overrun_clr,
   output logic                      ts_we,
   output logic [IdxW-1:0]           ts_idx,
   output logic [TimeStampWidth-1:0] ts_data,
   output logic [VecSize-1:0]        overrun,
   output logic                      busy
);

   localparam int AgeW = IdxW + 1;

   logic [VecSize-1:0]        pend_q_reg;
   logic [IdxW-1:0]           ptr_reg;
   logic                      ts_we_reg;
   logic [IdxW-1:0]           ts_idx_reg;
   logic [TimeStampWidth-1:0] ts_data_reg;

   logic [VecSize-1:0]        req_vec;
   logic [AgeW-1:0]           age_arr [VecSize];

   logic                      grant_valid;
   logic [IdxW-1:0]           grant_idx;
   logic [IdxW:0]             scan_sum;
   logic [IdxW-1:0]           scan_idx;
   logic [TimerWidth-1:0]     stamp_full;

   // Round-robin search starting at ptr; the first requester found wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      scan_sum    = '0;
      scan_idx    = '0;
      for (int i = 0; i < VecSize; i++) begin
         scan_sum = {1'b0, ptr_reg} + (IdxW+1)'(i);
         if (scan_sum >= (IdxW+1)'(VecSize)) begin
            scan_sum = scan_sum - (IdxW+1)'(VecSize);
         end
         scan_idx = scan_sum[IdxW-1:0];
         if (!grant_valid && req_vec[scan_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // A request granted now has waited age+1 cycles since its edge cycle, so
   // subtracting that recovers the edge-cycle timer value (modulo wrap).
   assign stamp_full = (mono_timer - TimerWidth'(age_arr[grant_idx]) - TimerWidth'(1))
                       >> TimeStampPreScaler;

   // Per-vector request, age and overrun state.
   generate
      for (genvar gi = 0; gi < VecSize; gi++) begin : g_vec
         logic            req_reg;
         logic [AgeW-1:0] age_reg;
         logic            overrun_reg;
         logic            rise;
         logic            gnt;

         assign rise = pend[gi] & ~pend_q_reg[gi] & cap_enable[gi];
         assign gnt  = grant_valid && (grant_idx == IdxW'(gi));

         always_ff @(posedge clk) begin
            if (reset) begin
               req_reg     <= 1'b0;
               age_reg     <= '0;
               overrun_reg <= 1'b0;
            end else begin
               if (rise && (!req_reg || gnt)) begin
                  // Fresh request, or a new edge arriving as the old one leaves.
                  req_reg <= 1'b1;
                  age_reg <= '0;
               end else if (req_reg && !gnt) begin
                  // Still waiting; a colliding edge keeps the oldest stamp.
                  if (age_reg != '1) begin
                     age_reg <= age_reg + AgeW'(1);
                  end
               end else if (gnt) begin
                  req_reg <= 1'b0;
               end

               // Setting wins over a simultaneous clear.
               if (rise && req_reg && !gnt) begin
                  overrun_reg <= 1'b1;
               end else if (overrun_clr[gi]) begin
                  overrun_reg <= 1'b0;
               end
            end
         end

         assign req_vec[gi] = req_reg;
         assign age_arr[gi] = age_reg;
         assign overrun[gi] = overrun_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q_reg  <= '0;
         ptr_reg     <= '0;
         ts_we_reg   <= 1'b0;
         ts_idx_reg  <= '0;
         ts_data_reg <= '0;
      end else begin
         pend_q_reg <= pend;
         ts_we_reg  <= grant_valid;
         if (grant_valid) begin
            ts_idx_reg  <= grant_idx;
            ts_data_reg <= TimeStampWidth'(stamp_full);
            if (grant_idx == IdxW'(VecSize - 1)) begin
               ptr_reg <= '0;
            end else begin
               ptr_reg <= grant_idx + IdxW'(1);
            end
         end
      end
   end

   assign ts_we   = ts_we_reg;
   assign ts_idx  = ts_idx_reg;
   assign ts_data = ts_data_reg;
   assign busy    = |req_vec;

endmodule

// File: doc/time_stamp_sched.md
Name: time_stamp_sched

Overview:
Capture scheduler for interrupt time stamps. It detects rising edges on per-vector pend lines and queues one capture request per vector. A round-robin arbiter then serialises the requests onto a single shared time-stamp write port (ext_data/ext_write_enable style), so only one write-capable stamp port is needed for VecSize sources. Per-request age counters back-correct each written stamp to the exact edge cycle, so arbitration delay never skews the stamp. It also flags overrun when a vector re-triggers before its previous stamp is written.

Parameters:
VecSize, 8, number of interrupt vectors; IdxW = $clog2(VecSize)
TimerWidth, 32, width of mono_timer
TimeStampWidth, 16, width of written stamp
TimeStampPreScaler, 4, right shift applied to corrected timer value

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mono_timer  in  TimerWidth  free-running timer; increments by exactly 1 per clk, wraps
pend  in  VecSize  per-vector pending lines
cap_enable  in  VecSize  per-vector capture mask; 0 = ignore edges
overrun_clr  in  VecSize  per-vector clear of sticky overrun
ts_we  out  1  stamp write strobe, one cycle per stamp
ts_idx  out  IdxW  vector index being written
ts_data  out  TimeStampWidth  stamp value
overrun  out  VecSize  sticky: edge lost while request outstanding
busy  out  1  |req (any request outstanding)

Behaviour:
- Reset: pend_q, req, age, overrun, ptr all cleared; ts_we=0, ts_idx=0, ts_data=0; busy=0. Reset mid-operation discards all outstanding requests without writing them. Because pend_q resets to 0, a pend held high through reset re-triggers on the first cycle after reset.
- Edge: edge[k] = pend[k] & ~pend_q[k] & cap_enable[k]. pend_q <= pend every cycle.
- Edge-cycle timer value T_e = mono_timer in the cycle edge[k]=1.
- Request state per k: req[k], age[k]. age width = IdxW+1, saturating at all-ones; saturation is unreachable in normal use.
  - edge[k] with req[k]=0, or with req[k] granted this cycle: req[k]<=1, age[k]<=0.
  - req[k]=1, not granted: age[k]<=age[k]+1.
  - edge[k] with req[k]=1 and not granted: overrun[k]<=1; req and age keep the original (oldest) edge.
  - granted, no new edge: req[k]<=0.
- Arbiter (combinational on registered req, one grant per cycle):
  - g = first index with req set, searching ptr, ptr+1, ..., VecSize-1, 0, ..., ptr-1.
  - On grant: ptr <= (g+1) mod VecSize; ptr is unchanged when there is no grant.
  - Worst-case wait from req set to grant is VecSize-1 cycles.
- Write output (registered; high in the cycle after the grant cycle):
  - ts_we <= grant_valid.
  - ts_idx <= g.
  - ts_data <= TimeStampWidth'(((mono_timer - age[g] - 1) mod 2^TimerWidth) >> TimeStampPreScaler).
  - This equals TimeStampWidth'(T_e >> TimeStampPreScaler).
  - Subtraction wraps modulo 2^TimerWidth; the result is truncated to the low bits after the shift.
  - ts_idx and ts_data hold their last value while ts_we=0.
- Latency: edge cycle c → req visible c+1 → earliest grant c+1 → ts_we high in c+2. Each cycle of arbitration wait adds 1.
- cap_enable[k] falling does not cancel an outstanding req[k]; that request is still written.
- overrun_clr[k] clears overrun[k]. A simultaneous set wins over clear.
- busy is combinational |req. Back-to-back grants produce ts_we high on consecutive cycles.

Test Plan:
1. Single stamp: PreScaler=0, pend[3] rises with mono_timer=100 in the edge cycle → exactly one write, 2 cycles later, ts_we=1, ts_idx=3, ts_data=100; busy high for 1 cycle.
2. Simultaneous edges: pend[0,2,5] rise at T_e=200, PreScaler=0 → writes on 3 consecutive cycles, idx 0,2,5, each ts_data=200; ptr ends at 6.
3. Round-robin order: after test 2 (ptr=6), pend[1] and pend[7] rise together → idx 7 written first, then idx 1; both carry the same T_e.
4. Overrun: all 8 pend rise at T_e=300, then pend[7] falls and rises again before its grant → overrun[7]=1, idx 7 ts_data=300 (oldest edge), only one idx-7 write. A following overrun_clr[7] → overrun[7]=0; clr pulsed with a coincident overrun edge → stays 1.
5. Wrap/prescale: PreScaler=4, edge at T_e=0xFFFF_FFFF, written while mono_timer has wrapped to 0x0000_0000 or later → ts_data=0xFFFF. Masked vector with cap_enable=0 rising → no write.
6. Reset mid-operation: 3 reqs outstanding, assert reset for 1 cycle → next cycle ts_we=0, busy=0, overrun=0, no stale writes afterwards. pend[4] held high through reset → one write with T_e = first post-reset cycle.
